// File: rtl/gpio_pkg.sv
// Shared constants for the nios_gpio_ctrl GPIO slave: register map,
// capture-edge selectors and the input warm-up terminal count.
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_ADDR_DATA    = 3'd0,
    GPIO_ADDR_DIR     = 3'd1,
    GPIO_ADDR_IRQMASK = 3'd2,
    GPIO_ADDR_EDGECAP = 3'd3,
    GPIO_ADDR_OUTSET  = 3'd4,
    GPIO_ADDR_OUTCLR  = 3'd5
  } gpio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam logic [1:0] WARMUP_DONE = 2'd3;

endpackage

// File: rtl/nios_gpio_ctrl_if.sv
// Avalon-MM slave bus bundle between the Nios data master and the GPIO block.
interface nios_gpio_ctrl_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser with a history register and edge selection;
// edges are suppressed while 'enable' is low so reset-time pin levels never capture.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic             enable,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] raw_edges;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pins;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  always_comb begin
    raw_edges = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: raw_edges = ~sync_q & prev_q;
      EDGE_ANY:     raw_edges = sync_q ^ prev_q;
      default:      raw_edges = sync_q & ~prev_q;
    endcase
  end

  assign sync_out = sync_q;
  assign edges    = enable ? raw_edges : '0;

endmodule

// File: rtl/nios_gpio_ctrl.sv
// Avalon-MM GPIO slave: data/direction/mask/edge-capture registers and irq.
// Define GPIO_BITSET_EN to add the atomic OUTSET/OUTCLR registers at addresses 4/5.
module nios_gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISING
) (
  input  logic              clk,
  input  logic              reset,
  nios_gpio_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  oe,
  output logic              irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edgecap;
  logic [1:0]       warm_cnt;
  logic             irq_q;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clear;
  logic [WIDTH-1:0] rd_val;
  logic             wr;
  logic             edge_enable;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.writedata};

  assign wr          = bus.chipselect & ~bus.write_n;
  assign wdata       = bus.writedata[WIDTH-1:0];
  assign edge_enable = (warm_cnt == WARMUP_DONE);
  assign cap_clear   = (wr && bus.address == GPIO_ADDR_EDGECAP) ? wdata : '0;

  gpio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .pins     (in_port),
    .enable   (edge_enable),
    .sync_out (sync_in),
    .edges    (edges)
  );

  // A new edge beats a simultaneous write-1-to-clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
      dir      <= DIR_RESET;
      mask     <= '0;
      edgecap  <= '0;
      warm_cnt <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && bus.address == GPIO_ADDR_DATA) begin
        data_out <= wdata;
      end
`ifdef GPIO_BITSET_EN
      else if (wr && bus.address == GPIO_ADDR_OUTSET) begin
        data_out <= data_out | wdata;
      end else if (wr && bus.address == GPIO_ADDR_OUTCLR) begin
        data_out <= data_out & ~wdata;
      end
`endif
      if (wr && bus.address == GPIO_ADDR_DIR) begin
        dir <= wdata;
      end
      if (wr && bus.address == GPIO_ADDR_IRQMASK) begin
        mask <= wdata;
      end
      edgecap <= (edgecap & ~cap_clear) | edges;
      if (warm_cnt != WARMUP_DONE) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
      irq_q <= |(edgecap & mask);
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus.address)
      GPIO_ADDR_DATA:    rd_val = (sync_in & ~dir) | (data_out & dir);
      GPIO_ADDR_DIR:     rd_val = dir;
      GPIO_ADDR_IRQMASK: rd_val = mask;
      GPIO_ADDR_EDGECAP: rd_val = edgecap;
      default:           rd_val = '0;
    endcase
  end

  assign bus.readdata = 32'(rd_val);
  assign out_port     = data_out;
  assign oe           = dir;
  assign irq          = irq_q;

endmodule

// File: doc/nios_gpio_ctrl.md
Name: nios_gpio_ctrl

Overview:
- Parametrised general-purpose I/O slave on the Nios Avalon-MM bus; next generation of the 8-bit output-only PIO.
- Adds configurable width, per-bit direction, synchronised inputs, edge capture with maskable interrupt, and atomic bit set/clear.
- Sits between the CPU data master and board pins (LEDs, switches, keys).

Parameters:
WIDTH, 8, number of I/O bits, 1..32
RESET_VALUE, 0, data_out value after reset (WIDTH bits)
DIR_RESET, all ones, direction register after reset; 1 = output
EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  read data, zero-extended above WIDTH
in_port  in  WIDTH  asynchronous pin inputs
out_port  out  WIDTH  data_out register
oe  out  WIDTH  output enable = direction register
irq  out  1  level interrupt request, active high

Behaviour:
- Write = chipselect & ~write_n, sampled at posedge clk. Reads are combinational with zero wait states; readdata depends on address only (chipselect ignored for reads, no read side effects).
- Register map:
  - 0 DATA: read = (sync_in & ~dir) | (data_out & dir); write loads data_out.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; write-1-to-clear per bit.
  - 4 OUTSET: write ORs into data_out; reads 0.
  - 5 OUTCLR: write clears bits of data_out; reads 0.
  - 6, 7: read 0, writes ignored.
- Reset:
  - data_out=RESET_VALUE, dir=DIR_RESET, mask=0, edgecap=0, sync stages=0.
  - Warm-up counter=0, so irq=0, out_port=RESET_VALUE, oe=DIR_RESET.
- Input path:
  - 2-flop synchroniser per bit, then a prev register.
  - Pin change visible in DATA reads 2 cycles after the clock edge that samples it.
  - Edge flag raised 3 cycles after sampling.
- Warm-up:
  - 2-bit counter counts 0..3 after reset and saturates.
  - Edge detection is disabled until the counter reaches 3, so pins held high through reset cause no spurious capture.
- Edge capture:
  - A bit sets on the selected edge, regardless of direction or mask.
  - A bit is sticky until cleared by a write of 1 to EDGECAP.
  - Edge and clear on the same bit in the same cycle: bit stays set (edge wins).
- irq = |(edgecap & mask), registered; asserts 1 cycle after the edgecap bit sets.
- Clearing the mask or edgecap deasserts irq on the next cycle.
- Reset asserted mid-operation overrides any write in the same cycle.

Optional Feature:
- GPIO_BITSET_EN defined: OUTSET/OUTCLR at addresses 4/5 behave as above.
- Not defined: addresses 4/5 read 0, writes ignored, and no set/clear logic is generated.
- DATA write behaviour is identical in both builds.

Decomposition:
- Package gpio_pkg holds:
  - address constants GPIO_ADDR_DATA..GPIO_ADDR_OUTCLR
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY
  - warm-up terminal count 3
- Sub-module gpio_sync_edge, instantiated once over the WIDTH-bit vector: synchroniser, prev register, edge-select logic, enable input from warm-up.
- Top level holds the register file, read mux and irq.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=8'hA5, in_port=8'hFF held → out_port=A5, oe=FF, read addr 3 = 0, irq=0 for 10 cycles.
- Write DIR=8'h0F, drive in_port=8'h30 → read DATA returns 8'h35 after 2 cycles (upper nibble from pins, lower from data_out 5).
- EDGE_TYPE=0, mask=8'h10, in_port bit4 0→1 → EDGECAP=8'h10 after 3 cycles, irq=1 next cycle; write EDGECAP=8'h10 → irq=0 next cycle.
- Same-cycle rising edge on bit2 and EDGECAP write 8'h04 → EDGECAP bit2 remains 1.
- With GPIO_BITSET_EN: data_out=8'h0F, write OUTSET=8'hF0 → FF, then write OUTCLR=8'h81 → 7E. Without GPIO_BITSET_EN: the same writes leave data_out=0F.
- Reset asserted in the same cycle as DATA write 8'h00 → out_port=RESET_VALUE, EDGECAP=0.
